fpu_op_sequencer: RTL and testbench
===================================

// Module: fpu_op_sequencer
// PURPOSE
//  Upstream command stage for the FPU datapath. Accepts one operation request at a time over a
//  valid/ready handshake and registers the operands. Drives the FPU load/en/operation inputs and
//  waits for completion (done, fixed latency or timeout), then holds the result on a
//  valid/ready response port until it is consumed.
// PARAMETERS
//  DW        64  operand/result width (FPU datapath width)
//  MUL_LAT   4   cycles from load to valid multiply result (multiplier has no done)
//  TIMEOUT   64  max RUN cycles waiting for fpu_done before aborting (>= MUL_LAT+1)
// PORTS
//  clk         in   1    clock, rising edge
//  reset       in   1    asynchronous, active-high
//  req_valid   in   1    request present
//  req_ready   out  1    sequencer can accept a request
//  req_a       in   DW   operand A (SP uses [31:0])
//  req_b       in   DW   operand B
//  req_op      in   2    00 add, 01 sub, 10 mul, 11 div
//  req_fmt     in   1    0 single (SP), 1 double (DP)
//  req_cin     in   1    carry-in forwarded to FPU
//  fpu_a       out  DW   registered operand A to FPU
//  fpu_b       out  DW   registered operand B to FPU
//  fpu_op      out  2    registered operation
//  fpu_type    out  1    registered format
//  fpu_cin     out  1    registered carry-in
//  fpu_load    out  1    one-cycle load strobe
//  fpu_en      out  1    FPU enable, high in LOAD and RUN
//  fpu_result  in   DW   FPU result
//  fpu_done    in   1    FPU completion (add/sub)
//  fpu_cout    in   1    FPU carry-out
//  rsp_valid   out  1    response present
//  rsp_ready   in   1    consumer accepts response
//  rsp_result  out  DW   captured result; SP zero-extended from [31:0]
//  rsp_cout    out  1    captured carry-out
//  rsp_err     out  2    00 ok, 01 timeout, 10 unsupported op/format
//  busy        out  1    state != IDLE
// BEHAVIOUR
//  - Reset (async): state IDLE; counter 0; all outputs 0 except req_ready=1.
//  - States: IDLE -> LOAD -> RUN -> RESP -> IDLE; IDLE -> RESP directly for unsupported ops.
//  - IDLE: req_ready=1. On req_valid, register a/b/op/fmt/cin.
//    - For SP, fpu_a/fpu_b[DW-1:32] are forced to 0.
//    - op=11, or fmt=1 (DP not yet supported): go to RESP with rsp_err=10, result 0.
//    - Otherwise go to LOAD.
//  - LOAD (1 cycle): fpu_load=1, fpu_en=1, counter cleared; next RUN.
//  - RUN: fpu_en=1, fpu_load=0, counter += 1 each cycle.
//    - add/sub: capture fpu_result and fpu_cout in the cycle fpu_done=1; go to RESP, err=00.
//    - mul: capture when counter == MUL_LAT-1; rsp_cout=0; err=00.
//    - counter == TIMEOUT-1 without completion: RESP, result 0, err=01.
//  - RESP: rsp_valid=1; rsp_result, rsp_cout and rsp_err are stable until rsp_valid && rsp_ready.
//    On that handshake go to IDLE.
//  - req_ready is 0 outside IDLE. No same-cycle response-to-request bypass, so the minimum spacing
//    between accepted requests is LOAD + RUN + RESP.
//  - fpu_a/b/op/type/cin hold their values from acceptance until the next acceptance.
//  - fpu_done outside RUN is ignored.
//  - Latency (add, done at RUN cycle k, k>=0): rsp_valid rises 2+k+1 cycles after the accept edge.
//  - reset asserted mid-operation aborts: the pending response is discarded and the state returns
//    to IDLE immediately.
//  - Counter width: $clog2(TIMEOUT+1); saturates, never wraps.
// STRUCTURE
//  - Shared package fpu_pkg:
//    - op codes OP_ADD/OP_SUB/OP_MUL/OP_DIV
//    - format codes FMT_SP/FMT_DP
//    - error codes ERR_OK/ERR_TIMEOUT/ERR_UNSUP
//    - state encoding
//  - Single module, no sub-modules. The RUN completion-select logic may be a local function.
// TESTING
//  1. SP add: a=0x3F800000 (1.0), b=0x40000000 (2.0); model done 3 cycles into RUN with result
//     0x40400000 -> rsp_result=0x0000_0000_4040_0000, err=00, rsp_valid 6 cycles after accept.
//  2. SP mul: a=0x40000000, b=0x40400000, MUL_LAT=4; model result 0x40C00000
//     -> captured at RUN counter 3, err=00, rsp_cout=0.
//  3. Timeout: add request, fpu_done held 0 -> after TIMEOUT RUN cycles rsp_valid=1, result=0,
//     err=01.
//  4. Unsupported: op=11 or fmt=1 -> fpu_load never pulses; rsp_valid next cycle, err=10.
//  5. Backpressure: rsp_ready=0 for 10 cycles -> rsp_* stable, req_ready=0, and a new req_valid
//     is not accepted until the handshake.
//  6. Reset mid-RUN: assert reset 2 cycles into RUN -> same cycle req_ready=1 and rsp_valid=0;
//     a stray fpu_done afterwards is ignored.

Source files
------------

// File: rtl/fpu_pkg.sv
// Encodings shared by the FPU command path: operations, formats, error codes, sequencer states.
package fpu_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } fpuOpE;

  typedef enum logic {
    FMT_SP = 1'b0,
    FMT_DP = 1'b1
  } fpuFmtE;

  typedef enum logic [1:0] {
    ERR_OK      = 2'b00,
    ERR_TIMEOUT = 2'b01,
    ERR_UNSUP   = 2'b10
  } fpuErrE;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_RUN  = 2'b10,
    ST_RESP = 2'b11
  } seqStateE;

  localparam int SP_W = 32;

endpackage

// File: rtl/fpu_op_sequencer.sv
// Command stage in front of the FPU: accepts one request, launches it, waits for completion
// (done, fixed multiply latency or timeout) and holds the response until it is consumed.
module fpu_op_sequencer
  import fpu_pkg::*;
#(
  parameter int DW      = 64,
  parameter int MUL_LAT = 4,
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [DW-1:0] req_a,
  input  logic [DW-1:0] req_b,
  input  logic [1:0]    req_op,
  input  logic          req_fmt,
  input  logic          req_cin,
  output logic [DW-1:0] fpu_a,
  output logic [DW-1:0] fpu_b,
  output logic [1:0]    fpu_op,
  output logic          fpu_type,
  output logic          fpu_cin,
  output logic          fpu_load,
  output logic          fpu_en,
  input  logic [DW-1:0] fpu_result,
  input  logic          fpu_done,
  input  logic          fpu_cout,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_result,
  output logic          rsp_cout,
  output logic [1:0]    rsp_err,
  output logic          busy
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] MUL_LAST = CW'(MUL_LAT - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  seqStateE      state, nextState;
  logic [CW-1:0] cnt;
  logic          accept, unsup, opDone, timedOut;
  logic [DW-1:0] capResult;
  logic          capCout;

  // Add/sub finish on the FPU's done; the multiplier has no done and finishes on a fixed count.
  function automatic logic runComplete(input logic [1:0] op, input logic done,
                                       input logic [CW-1:0] count);
    return ((op == OP_ADD || op == OP_SUB) && done) || (op == OP_MUL && count == MUL_LAST);
  endfunction

  assign accept = (state == ST_IDLE) && req_valid;
  assign unsup  = (req_op == OP_DIV) || (req_fmt == FMT_DP);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    opDone    = 1'b0;
    timedOut  = 1'b0;
    case (state)
      ST_IDLE: if (req_valid) nextState = unsup ? ST_RESP : ST_LOAD;
      ST_LOAD: nextState = ST_RUN;
      ST_RUN: begin
        if (runComplete(fpu_op, fpu_done, cnt)) begin
          opDone    = 1'b1;
          nextState = ST_RESP;
        end else if (cnt == TO_LAST) begin
          timedOut  = 1'b1;
          nextState = ST_RESP;
        end
      end
      ST_RESP: if (rsp_ready) nextState = ST_IDLE;
      default: nextState = ST_IDLE;
    endcase
  end

  assign req_ready = (state == ST_IDLE);
  assign fpu_load  = (state == ST_LOAD);
  assign fpu_en    = (state == ST_LOAD) || (state == ST_RUN);
  assign rsp_valid = (state == ST_RESP);
  assign busy      = (state != ST_IDLE);

  assign capResult = (fpu_type == FMT_SP) ? {{(DW-SP_W){1'b0}}, fpu_result[SP_W-1:0]} : fpu_result;
  assign capCout   = (fpu_op == OP_MUL) ? 1'b0 : fpu_cout;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      fpu_a      <= '0;
      fpu_b      <= '0;
      fpu_op     <= '0;
      fpu_type   <= 1'b0;
      fpu_cin    <= 1'b0;
      rsp_result <= '0;
      rsp_cout   <= 1'b0;
      rsp_err    <= ERR_OK;
    end else begin
      if (accept) begin
        fpu_a    <= (req_fmt == FMT_SP) ? {{(DW-SP_W){1'b0}}, req_a[SP_W-1:0]} : req_a;
        fpu_b    <= (req_fmt == FMT_SP) ? {{(DW-SP_W){1'b0}}, req_b[SP_W-1:0]} : req_b;
        fpu_op   <= req_op;
        fpu_type <= req_fmt;
        fpu_cin  <= req_cin;
        if (unsup) begin
          rsp_result <= '0;
          rsp_cout   <= 1'b0;
          rsp_err    <= ERR_UNSUP;
        end
      end
      if (state == ST_LOAD)                      cnt <= '0;
      else if (state == ST_RUN && cnt != CNT_MAX) cnt <= cnt + 1'b1;
      if (opDone) begin
        rsp_result <= capResult;
        rsp_cout   <= capCout;
        rsp_err    <= ERR_OK;
      end else if (timedOut) begin
        rsp_result <= '0;
        rsp_cout   <= 1'b0;
        rsp_err    <= ERR_TIMEOUT;
      end
    end
  end

endmodule

// File: tb/tb_fpu_op_sequencer.sv
// Self-checking bench for fpu_op_sequencer: vector table plus hand-written reset/backpressure cases.
module tb_fpu_op_sequencer;

  localparam int DW      = 64;
  localparam int MUL_LAT = 4;
  localparam int TIMEOUT = 64;

  logic          clk, reset;
  logic          req_valid, req_ready;
  logic [DW-1:0] req_a, req_b;
  logic [1:0]    req_op;
  logic          req_fmt, req_cin;
  logic [DW-1:0] fpu_a, fpu_b;
  logic [1:0]    fpu_op;
  logic          fpu_type, fpu_cin, fpu_load, fpu_en;
  logic [DW-1:0] fpu_result;
  logic          fpu_done, fpu_cout;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_result;
  logic          rsp_cout;
  logic [1:0]    rsp_err;
  logic          busy;

  fpu_op_sequencer #(.DW(DW), .MUL_LAT(MUL_LAT), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_fmt(req_fmt), .req_cin(req_cin),
    .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_op(fpu_op), .fpu_type(fpu_type), .fpu_cin(fpu_cin),
    .fpu_load(fpu_load), .fpu_en(fpu_en),
    .fpu_result(fpu_result), .fpu_done(fpu_done), .fpu_cout(fpu_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_cout(rsp_cout), .rsp_err(rsp_err),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [1:0]  op;
    logic        fmt;
    logic        cin;
    int          doneK;     // RUN cycle with fpu_done for add/sub, -1 = never
    logic [63:0] res;       // value the FPU model presents in its completion cycle
    logic        cout;
    int          hold;      // cycles of rsp_ready=0 after rsp_valid
    logic [63:0] expRes;
    logic        expCout;
    logic [1:0]  expErr;
    int          expLat;    // edges from and including the accept edge to the edge raising rsp_valid
    int          expLoads;
  } vecT;

  typedef struct {
    logic [63:0] res;
    logic        cout;
    logic [1:0]  err;
  } rspT;

  rspT sb[$];
  vecT vecs[8];
  int  checks = 0;
  int  failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic resetPulse();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic doTxn(input int idx, input vecT v);
    int          acc, loads, runIdx, capIdx;
    logic [63:0] expA, expB;
    logic        addSub;
    rspT         r;
    string       tag;
    tag    = $sformatf("v%0d", idx);
    addSub = (v.op == 2'b00) || (v.op == 2'b01);
    capIdx = addSub ? v.doneK : ((v.op == 2'b10) ? MUL_LAT - 1 : -1);
    expA   = (v.fmt == 1'b0) ? {32'h0, v.a[31:0]} : v.a;
    expB   = (v.fmt == 1'b0) ? {32'h0, v.b[31:0]} : v.b;

    @(negedge clk);
    check({tag, "_req_ready_idle"}, 64'(req_ready), 64'd1);
    req_valid = 1'b1;
    req_a = v.a; req_b = v.b; req_op = v.op; req_fmt = v.fmt; req_cin = v.cin;
    sb.push_back('{res: v.expRes, cout: v.expCout, err: v.expErr});
    acc = cyc + 1;
    @(negedge clk);
    req_valid = 1'b0;
    req_a = '0; req_b = '0;
    check({tag, "_fpu_a"}, fpu_a, expA);
    check({tag, "_fpu_b"}, fpu_b, expB);
    check({tag, "_fpu_op_fmt_cin"}, 64'({fpu_op, fpu_type, fpu_cin}), 64'({v.op, v.fmt, v.cin}));

    loads  = 0;
    runIdx = 0;
    for (int t = 0; t < 200; t++) begin
      if (rsp_valid) break;
      fpu_result = {$urandom, $urandom};
      fpu_cout   = ~v.cout;
      fpu_done   = 1'b0;
      if (fpu_load) begin
        loads++;
        fpu_done = addSub;   // stray done outside RUN
      end else if (fpu_en) begin
        fpu_done = addSub && (runIdx == v.doneK);
        if (runIdx == capIdx) begin
          fpu_result = v.res;
          fpu_cout   = v.cout;
        end
        runIdx++;
      end
      @(negedge clk);
    end
    fpu_done = 1'b0;
    check({tag, "_rsp_valid_seen"}, 64'(rsp_valid), 64'd1);
    if (!rsp_valid) begin
      void'(sb.pop_front());
      resetPulse();
      return;
    end
    check({tag, "_latency"}, 64'(cyc - acc + 1), 64'(v.expLat));
    check({tag, "_load_pulses"}, 64'(loads), 64'(v.expLoads));
    r = sb.pop_front();
    check({tag, "_rsp_result"}, rsp_result, r.res);
    check({tag, "_rsp_cout"}, 64'(rsp_cout), 64'(r.cout));
    check({tag, "_rsp_err"}, 64'(rsp_err), 64'(r.err));

    if (v.hold > 0) begin
      req_valid = 1'b1;
      req_a = ~v.a; req_b = ~v.b; req_op = 2'b00; req_fmt = 1'b0; req_cin = ~v.cin;
    end
    for (int i = 0; i < v.hold; i++) begin
      fpu_done   = 1'b1;
      fpu_result = {$urandom, $urandom};
      @(negedge clk);
      check({tag, "_bp_valid"}, 64'(rsp_valid), 64'd1);
      check({tag, "_bp_result"}, rsp_result, r.res);
      check({tag, "_bp_cout_err"}, 64'({rsp_cout, rsp_err}), 64'({r.cout, r.err}));
      check({tag, "_bp_req_ready"}, 64'(req_ready), 64'd0);
      check({tag, "_bp_no_accept"}, fpu_a, expA);
    end
    fpu_done  = 1'b0;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check({tag, "_post_hs_idle"}, 64'({rsp_valid, req_ready, busy}), 64'b010);
  endtask

  initial begin
    // SP add 1.0 + 2.0, done 3 cycles into RUN; upper operand bits must be dropped
    vecs[0] = '{a: 64'hDEAD_BEEF_3F80_0000, b: 64'h1234_5678_4000_0000, op: 2'b00, fmt: 1'b0, cin: 1'b0,
                doneK: 3, res: 64'hFFFF_FFFF_4040_0000, cout: 1'b1, hold: 0,
                expRes: 64'h0000_0000_4040_0000, expCout: 1'b1, expErr: 2'b00, expLat: 6, expLoads: 1};
    vecs[1] = '{a: 64'h0000_0000_4040_0000, b: 64'h0000_0000_3F80_0000, op: 2'b01, fmt: 1'b0, cin: 1'b0,
                doneK: 0, res: 64'hA5A5_0000_4000_0000, cout: 1'b0, hold: 0,
                expRes: 64'h0000_0000_4000_0000, expCout: 1'b0, expErr: 2'b00, expLat: 3, expLoads: 1};
    vecs[2] = '{a: 64'h0000_0000_4000_0000, b: 64'h0000_0000_4040_0000, op: 2'b10, fmt: 1'b0, cin: 1'b0,
                doneK: -1, res: 64'h0000_0000_40C0_0000, cout: 1'b1, hold: 0,
                expRes: 64'h0000_0000_40C0_0000, expCout: 1'b0, expErr: 2'b00, expLat: 6, expLoads: 1};
    vecs[3] = '{a: 64'h0000_0000_3F80_0000, b: 64'h0000_0000_3F80_0000, op: 2'b00, fmt: 1'b0, cin: 1'b0,
                doneK: -1, res: 64'h0000_0000_4000_0000, cout: 1'b1, hold: 0,
                expRes: 64'h0, expCout: 1'b0, expErr: 2'b01, expLat: TIMEOUT + 2, expLoads: 1};
    vecs[4] = '{a: 64'h0000_0000_4080_0000, b: 64'h0000_0000_4000_0000, op: 2'b11, fmt: 1'b0, cin: 1'b1,
                doneK: 0, res: 64'h1, cout: 1'b1, hold: 0,
                expRes: 64'h0, expCout: 1'b0, expErr: 2'b10, expLat: 1, expLoads: 0};
    vecs[5] = '{a: 64'h3FF0_0000_0000_0000, b: 64'h4000_0000_0000_0000, op: 2'b00, fmt: 1'b1, cin: 1'b0,
                doneK: 0, res: 64'h1, cout: 1'b1, hold: 0,
                expRes: 64'h0, expCout: 1'b0, expErr: 2'b10, expLat: 1, expLoads: 0};
    vecs[6] = '{a: 64'h0000_0000_4120_0000, b: 64'h0000_0000_3F80_0000, op: 2'b00, fmt: 1'b0, cin: 1'b0,
                doneK: 1, res: 64'h0000_0000_4130_0000, cout: 1'b1, hold: 10,
                expRes: 64'h0000_0000_4130_0000, expCout: 1'b1, expErr: 2'b00, expLat: 4, expLoads: 1};
    vecs[7] = '{a: 64'h0000_0000_C000_0000, b: 64'h0000_0000_4000_0000, op: 2'b01, fmt: 1'b0, cin: 1'b1,
                doneK: 5, res: 64'h0000_0000_C080_0000, cout: 1'b1, hold: 0,
                expRes: 64'h0000_0000_C080_0000, expCout: 1'b1, expErr: 2'b00, expLat: 8, expLoads: 1};

    reset = 1'b1;
    req_valid = 1'b0; req_a = '0; req_b = '0; req_op = '0; req_fmt = 1'b0; req_cin = 1'b0;
    fpu_result = '0; fpu_done = 1'b0; fpu_cout = 1'b0; rsp_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("reset_ctrl", 64'({req_ready, rsp_valid, busy, fpu_load, fpu_en}), 64'b10000);
    check("reset_regs", 64'({rsp_err, rsp_cout, fpu_op, fpu_type, fpu_cin}), 64'd0);
    check("reset_data", fpu_a | fpu_b | rsp_result, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) doTxn(i, vecs[i]);

    // Reset two cycles into RUN aborts the pending add; later stray done is ignored
    @(negedge clk);
    req_valid = 1'b1;
    req_a = 64'h0000_0000_3F80_0000; req_b = 64'h0000_0000_3F80_0000;
    req_op = 2'b00; req_fmt = 1'b0; req_cin = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    check("rst_load", 64'(fpu_load), 64'd1);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("rst_in_run", 64'({fpu_en, fpu_load, busy}), 64'b101);
    reset = 1'b1;
    #1;
    check("rst_immediate", 64'({req_ready, rsp_valid, busy, fpu_en}), 64'b1000);
    @(negedge clk);
    reset = 1'b0;
    fpu_done = 1'b1;
    fpu_result = 64'h0000_0000_4000_0000;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rst_stray_done", 64'({rsp_valid, busy, req_ready}), 64'b001);
    end
    fpu_done = 1'b0;

    doTxn(8, vecs[0]);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
